eff_sw_ctrl: RTL and testbench
==============================

// Module: eff_sw_ctrl
// PURPOSE
//  Control front-end for eff_pipe. Synchronises/debounces board switches (bypass
//  enable + 16-bit effect select), drives eff_pipe en/sel, and applies a click-free
//  fade-out -> swap -> settle -> fade-in gain ramp to the eff_pipe output stream
//  so effect changes never produce pops. Sits between eff_pipe and the DAC path.
// PARAMETERS
//  DB_CYCLES  1_000_000  clk cycles a synced switch value must hold before it is accepted
//  GAIN_W     8          ramp resolution; full-scale gain = 2**GAIN_W (ramp = 2**GAIN_W samples)
//  SETTLE     16         valid samples held at gain 0 after swap to flush eff_pipe
// PORTS
//  clk     in   1        system clock
//  rst     in   1        synchronous, active-high reset
//  sw_en   in   1        raw async effect-enable switch
//  sw_sel  in   16       raw async effect-select switches
//  en_o    out  1        to eff_pipe.en
//  sel_o   out  16       to eff_pipe.sel
//  data_i  in   sample_t eff_pipe output sample {lc, rc}, signed
//  vld_i   in   1        data_i valid strobe
//  data_o  out  sample_t gain-scaled sample
//  vld_o   out  1        data_o valid strobe
//  busy    out  1        high whenever state != IDLE
// BEHAVIOUR
//  Reset: en_o=0, sel_o=0, data_o=0, vld_o=0, busy=0, state=IDLE, gain=2**GAIN_W,
//   debounced value={0,0}, pending={0,0}, debounce counter=0, settle counter=0.
//  Input sync: 2-FF synchroniser on all 17 switch bits.
//  Debounce: counter clears whenever synced 17-bit word differs from previous cycle;
//   when it reaches DB_CYCLES-1 while stable, word is accepted into pending. A
//   "change" event fires the cycle pending becomes != {en_o, sel_o}.
//  FSM (gain steps only on cycles with vld_i=1):
//   IDLE:     gain=full. On change -> FADE_OUT.
//   FADE_OUT: gain -= 1 per valid sample; on the valid sample that makes gain 0 -> SWAP.
//             Further changes just update pending.
//   SWAP:     one cycle: {en_o, sel_o} <= pending; settle counter=0 -> SETTLE.
//   SETTLE:   gain held 0; count valid samples; after SETTLE of them -> FADE_IN.
//             A change here -> SWAP (re-load, restart settle).
//   FADE_IN:  gain += 1 per valid sample; reaching full -> IDLE.
//             A change here -> FADE_OUT from current gain (no jump).
//  en_o/sel_o change ONLY in SWAP, i.e. only while gain is 0.
//  Datapath: 2-cycle latency, independent of FSM. Stage1 registers lc*g, rc*g
//   (signed, SAMPLE_W+GAIN_W+1 bits) using gain value in effect that cycle; stage2
//   registers arithmetic >>> GAIN_W (floor), truncated to SAMPLE_W. g=full -> exact
//   passthrough; g=0 -> 0. vld_o = vld_i delayed 2 cycles. Gain update from a
//   sample takes effect on the next sample.
//  vld_i gaps: gain/settle frozen; no samples dropped or duplicated.
//  Reset mid-ramp: everything returns to reset values next cycle; pipeline flushed
//   (vld_o=0 for 2 cycles after rst deassert unless vld_i).
//  Switches already high at reset -> normal debounce then full fade/swap sequence.
// TESTING (DB_CYCLES=4, GAIN_W=2, SETTLE=2, vld_i every cycle, lc=1000, rc=-999)
//  1 Reset then stream: data_o.lc=1000, rc=-999 two cycles after each vld_i; en_o=0, busy=0.
//  2 Toggle sw_en 0->1 and hold: busy rises 2+4 cycles later; data_o.lc 1000,750,500,250,
//    0,0,0, then 250,500,750,1000; rc -750(floor of -2997/4),-500,-250,0..; en_o
//    flips only while output is 0; busy falls at full gain.
//  3 Pulse sw_sel[3] high for 3 cycles only -> no change event, busy stays 0, data unchanged.
//  4 Change sw_sel during FADE_IN at gain 2 -> gain ramps 2->1->0 (no jump), sel_o takes
//    newest value, then fades back to full.
//  5 vld_i asserted every 3rd cycle during fade -> one gain step per valid sample; vld_o
//    count equals vld_i count.
//  6 Assert rst at gain 1 in FADE_OUT -> next cycle en_o=0, sel_o=0, busy=0, vld_o=0;
//    subsequent stream passes at full gain.

Source files
------------

// File: rtl/eff_sw_ctrl.sv
// Switch front-end for eff_pipe: synchronises and debounces the board switches, then
// hides every effect change behind a fade-out / swap / settle / fade-in gain ramp.
module eff_sw_ctrl #(
  parameter int DB_CYCLES = 1_000_000,
  parameter int GAIN_W    = 8,
  parameter int SETTLE    = 16,
  parameter int SAMPLE_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    sw_en,
  input  logic [15:0]             sw_sel,
  output logic                    en_o,
  output logic [15:0]             sel_o,
  input  logic [2*SAMPLE_W-1:0]   data_i,
  input  logic                    vld_i,
  output logic [2*SAMPLE_W-1:0]   data_o,
  output logic                    vld_o,
  output logic                    busy,
  output logic [2:0]              state_o
);

  localparam int PW  = SAMPLE_W + GAIN_W + 1;
  localparam int DBW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam int STW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [DBW-1:0]  DB_LAST = DBW'(DB_CYCLES - 1);
  localparam logic [STW-1:0]  ST_LAST = STW'(SETTLE - 1);
  localparam logic [GAIN_W:0] G_FULL  = {1'b1, {GAIN_W{1'b0}}};
  localparam logic [GAIN_W:0] G_ONE   = (GAIN_W + 1)'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_FADE_OUT, S_SWAP, S_SETTLE, S_FADE_IN
  } state_t;

  logic [16:0]      sync1_q, sync2_q, prev_q, pending_q;
  logic [DBW-1:0]   db_cnt_q;
  state_t           state_q;
  logic [GAIN_W:0]  gain_q;
  logic [STW-1:0]   settle_q;
  logic             en_q, busy_q;
  logic [15:0]      sel_q;
  logic             change;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      prev_q    <= '0;
      db_cnt_q  <= '0;
      pending_q <= '0;
    end else begin
      sync1_q <= {sw_en, sw_sel};
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      if (sync2_q != prev_q)
        db_cnt_q <= '0;
      else if (db_cnt_q != DB_LAST)
        db_cnt_q <= db_cnt_q + 1'b1;
      else
        pending_q <= prev_q;
    end
  end

  assign change = (pending_q != {en_q, sel_q});

  // Gain only moves on valid samples, so vld_i gaps freeze the ramp in place.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      gain_q   <= G_FULL;
      settle_q <= '0;
      en_q     <= 1'b0;
      sel_q    <= '0;
      busy_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (change) begin
            state_q <= S_FADE_OUT;
            busy_q  <= 1'b1;
          end
        end
        S_FADE_OUT: begin
          if (vld_i) begin
            gain_q <= gain_q - 1'b1;
            if (gain_q == G_ONE) state_q <= S_SWAP;
          end
        end
        S_SWAP: begin
          {en_q, sel_q} <= pending_q;
          settle_q      <= '0;
          state_q       <= S_SETTLE;
        end
        S_SETTLE: begin
          if (change) begin
            state_q <= S_SWAP;
          end else if (vld_i) begin
            // The last settle sample already takes the first fade-in step.
            if (settle_q == ST_LAST) begin
              settle_q <= '0;
              gain_q   <= G_ONE;
              state_q  <= S_FADE_IN;
            end else begin
              settle_q <= settle_q + 1'b1;
            end
          end
        end
        S_FADE_IN: begin
          if (change) begin
            state_q <= S_FADE_OUT;
          end else if (vld_i) begin
            gain_q <= gain_q + 1'b1;
            if (gain_q == G_FULL - G_ONE) begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  logic signed [SAMPLE_W-1:0] lc_s, rc_s;
  logic signed [GAIN_W+1:0]   g_s;
  logic signed [PW-1:0]       lc_mul_d, rc_mul_d, lc_mul_q, rc_mul_q;
  logic                       vld1_q, vld2_q;
  logic [2*SAMPLE_W-1:0]      data_q;

  assign lc_s     = data_i[2*SAMPLE_W-1:SAMPLE_W];
  assign rc_s     = data_i[SAMPLE_W-1:0];
  assign g_s      = $signed({1'b0, gain_q});
  assign lc_mul_d = PW'(lc_s) * PW'(g_s);
  assign rc_mul_d = PW'(rc_s) * PW'(g_s);

  always_ff @(posedge clk) begin
    if (rst) begin
      lc_mul_q <= '0;
      rc_mul_q <= '0;
      vld1_q   <= 1'b0;
      data_q   <= '0;
      vld2_q   <= 1'b0;
    end else begin
      lc_mul_q <= lc_mul_d;
      rc_mul_q <= rc_mul_d;
      vld1_q   <= vld_i;
      data_q   <= {SAMPLE_W'(lc_mul_q >>> GAIN_W), SAMPLE_W'(rc_mul_q >>> GAIN_W)};
      vld2_q   <= vld1_q;
    end
  end

  assign en_o    = en_q;
  assign sel_o   = sel_q;
  assign data_o  = data_q;
  assign vld_o   = vld2_q;
  assign busy    = busy_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_eff_sw_ctrl.sv
// Randomised bench for eff_sw_ctrl: a sample-level reference model predicts gain,
// switch outputs and every scaled sample; a monitor checks them against the DUT.
module tb_eff_sw_ctrl;

  localparam int DB   = 4;
  localparam int GW   = 2;
  localparam int ST   = 2;
  localparam int FULL = 1 << GW;
  localparam logic [15:0] LC = 16'd1000;
  localparam logic [15:0] RC = 16'hFC19;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sw_en = 1'b0;
  logic [15:0] sw_sel = '0;
  logic [31:0] data_i = '0;
  logic        vld_i = 1'b0;
  logic        en_o, vld_o, busy;
  logic [15:0] sel_o;
  logic [31:0] data_o;
  logic [2:0]  state_o;

  always #5 clk = ~clk;

  eff_sw_ctrl #(.DB_CYCLES(DB), .GAIN_W(GW), .SETTLE(ST), .SAMPLE_W(16)) dut (
    .clk(clk), .rst(rst), .sw_en(sw_en), .sw_sel(sw_sel), .en_o(en_o), .sel_o(sel_o),
    .data_i(data_i), .vld_i(vld_i), .data_o(data_o), .vld_o(vld_o), .busy(busy),
    .state_o(state_o)
  );

  // ---------------- bookkeeping ----------------
  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int vin_cnt = 0;
  int vout_cnt = 0;
  int busy_cnt = 0;
  logic [63:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] scale(input logic [15:0] x, input int g);
    int p, q;
    p = int'($signed(x)) * g;
    q = p / FULL;
    if (p < 0 && (p % FULL) != 0) q = q - 1;
    return q[15:0];
  endfunction

  // ---------------- reference model ----------------
  // Gain is tracked as a level plus a ramp direction; the switch path is a raw-sample
  // history that accepts a word once it has been seen DB+1 times in a row, 2 cycles late.
  int          m_g = FULL;
  int          m_dir = 0;
  int          m_hold = 0;
  bit          m_swap = 0;
  logic [16:0] m_cur = '0;
  logic [16:0] m_pend = '0;
  logic [16:0] hist[$];
  bit          chg;
  bit          same;

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      hist.delete();
      for (int i = 0; i < DB + 3; i++) hist.push_back('0);
      m_pend = '0; m_cur = '0; m_g = FULL; m_dir = 0; m_hold = 0; m_swap = 0;
      exp_q.delete();
    end else begin
      if (vld_i)
        exp_q.push_back({32'(cyc + 1), scale(data_i[31:16], m_g), scale(data_i[15:0], m_g)});
      chg = (m_pend != m_cur);
      if (m_swap) begin
        m_cur = m_pend; m_swap = 0; m_hold = ST;
      end else if (m_hold > 0) begin
        if (chg) m_swap = 1;
        else if (vld_i) begin
          m_hold--;
          if (m_hold == 0) begin m_g = 1; m_dir = 1; end
        end
      end else if (m_dir < 0) begin
        if (vld_i) begin
          m_g--;
          if (m_g == 0) begin m_swap = 1; m_dir = 0; end
        end
      end else if (m_dir > 0) begin
        if (chg) m_dir = -1;
        else if (vld_i) begin
          m_g++;
          if (m_g == FULL) m_dir = 0;
        end
      end else if (chg) begin
        m_dir = -1;
      end
      hist.push_back({sw_en, sw_sel});
      void'(hist.pop_front());
      same = 1;
      for (int i = 1; i <= DB; i++) if (hist[i] != hist[0]) same = 0;
      if (same) m_pend = hist[DB];
    end
  end

  // ---------------- monitor / scoreboard ----------------
  logic [63:0] e;
  always @(negedge clk) begin
    if (cyc > 0) begin
      check("busy", 64'(busy), 64'(m_dir != 0 || m_hold > 0 || m_swap));
      check("en_o", 64'(en_o), 64'(m_cur[16]));
      check("sel_o", 64'(sel_o), 64'(m_cur[15:0]));
      if (busy) busy_cnt++;
      if (vld_o) begin
        vout_cnt++;
        if (exp_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL vld_o_extra: got sample %h, expected no output (cycle %0d)", data_o, cyc);
        end else begin
          e = exp_q.pop_front();
          check("data_o{due,lc,rc}", {32'(cyc), data_o}, e);
        end
      end else if (exp_q.size() > 0 && int'(exp_q[0][63:32]) <= cyc) begin
        n_cmp++; n_err++;
        $display("FAIL vld_o_missing: got no output, expected %h (cycle %0d)", exp_q[0][31:0], cyc);
        void'(exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic v, input logic [15:0] lc, input logic [15:0] rc);
    @(negedge clk);
    vld_i  = v;
    data_i = {lc, rc};
    if (v && !rst) vin_cnt++;
  endtask

  task automatic drive_rand(input logic v);
    drive(v, 16'($urandom), 16'($urandom));
  endtask

  // Streams until the model reaches the requested ramp point; the inputs for the next
  // edge are left idle so the caller acts before any further gain step.
  task automatic stream_until(input int dir, input int g, output bit found);
    found = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (m_dir == dir && m_g == g) begin found = 1; break; end
      vld_i  = 1'b1;
      data_i = {16'($urandom), 16'($urandom)};
    end
    vld_i = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  bit found;
  initial begin
    // reset state
    repeat (3) @(negedge clk);
    check("rst_data_o", 64'(data_o), 64'd0);
    check("rst_vld_o", 64'(vld_o), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    rst = 1'b0;

    // steady stream at full gain
    repeat (10) drive(1'b1, LC, RC);

    // enable toggle: full fade/swap/settle/fade-in
    sw_en = 1'b1;
    repeat (40) drive(1'b1, LC, RC);
    check("en_after_toggle", 64'(en_o), 64'd1);

    // short glitch is rejected
    busy_cnt = 0;
    sw_sel[3] = 1'b1;
    repeat (3) drive(1'b1, LC, RC);
    sw_sel[3] = 1'b0;
    repeat (20) drive(1'b1, LC, RC);
    check("glitch_busy_cycles", 64'(busy_cnt), 64'd0);

    // change arriving mid fade-in, with the ramp frozen by a vld_i gap
    sw_sel = 16'h00A5;
    stream_until(1, 2, found);
    check("reach_fade_in_g2", 64'(found), 64'd1);
    sw_sel = 16'h5A00;
    repeat (12) drive(1'b0, 16'h0, 16'h0);
    repeat (30) drive_rand(1'b1);
    check("sel_newest", 64'(sel_o), 64'h5A00);
    repeat (4) drive(1'b0, 16'h0, 16'h0);

    // sparse valid strobes during a fade
    vin_cnt = 0; vout_cnt = 0;
    sw_en = 1'b0;
    for (int i = 0; i < 90; i++) drive_rand(i % 3 == 0);
    repeat (4) drive(1'b0, 16'h0, 16'h0);
    check("vld_count", 64'(vout_cnt), 64'(vin_cnt));
    check("en_after_sparse", 64'(en_o), 64'd0);

    // reset in FADE_OUT at gain 1
    sw_sel = 16'h0F0F;
    stream_until(-1, 1, found);
    check("reach_fade_out_g1", 64'(found), 64'd1);
    rst = 1'b1; vld_i = 1'b1; data_i = {LC, RC};
    @(negedge clk);
    check("midrst_vld_o", 64'(vld_o), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_sel_o", 64'(sel_o), 64'd0);
    rst = 1'b0;
    repeat (60) drive(1'b1, LC, RC);
    check("sel_after_rst", 64'(sel_o), 64'h0F0F);

    // random switches, samples and strobe gaps
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 39) == 0) {sw_en, sw_sel} = 17'($urandom);
      drive_rand($urandom_range(0, 3) != 0);
    end
    repeat (40) drive_rand(1'b1);
    repeat (5) drive(1'b0, 16'h0, 16'h0);
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    n_err++;
    $display("FAIL watchdog: got no end of test, expected finish before time limit");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
